// File: rtl/sqrt_sync_bridge.sv
// Clocked front-end for the self-timed sqrt stage: valid/ready operand in, four-phase
// req/fin handshake to sqrt, synchronised fin, captured root out, per-phase timeout.
module sqrt_sync_bridge #(
  parameter int Width      = 32,
  parameter int SyncStages = 2,
  parameter int Timeout    = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_y,
  output logic             out_err,
  output logic             sq_req,
  output logic [Width-1:0] sq_x,
  input  logic             sq_fin,
  input  logic [Width-1:0] sq_y
);

  localparam int TW = (Timeout > 0) ? $clog2(Timeout + 1) : 1;
  localparam logic [TW-1:0] TLAST = (Timeout > 0) ? TW'(Timeout - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_REQ_HI, S_REQ_LO, S_OUT} state_t;

  state_t                r_state;
  logic [SyncStages-1:0] r_sync;
  logic [TW-1:0]         r_timer;
  logic                  r_sq_req;
  logic [Width-1:0]      r_sq_x;
  logic                  r_out_valid;
  logic [Width-1:0]      r_out_y;
  logic                  r_out_err;

  logic                  w_fin_s;
  logic                  w_in_ready;
  logic                  w_tmo;
  logic [TW-1:0]         w_timer_inc;

  assign w_fin_s     = r_sync[SyncStages-1];
  // A stale fin (e.g. left high by a reset mid-operation) must drain before a new request.
  assign w_in_ready  = (r_state == S_IDLE) && !w_fin_s;
  assign w_tmo       = (Timeout != 0) && (r_timer == TLAST);
  assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SyncStages-2:0], sq_fin};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_sq_req    <= 1'b0;
      r_sq_x      <= '0;
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && w_in_ready) begin
            r_sq_x    <= in_x;
            r_sq_req  <= 1'b1;
            r_timer   <= '0;
            r_out_err <= 1'b0;
            r_state   <= S_REQ_HI;
          end
        end
        S_REQ_HI: begin
          if (w_fin_s) begin
            r_out_y  <= sq_y;
            r_sq_req <= 1'b0;
            r_timer  <= '0;
            r_state  <= S_REQ_LO;
          end else if (w_tmo) begin
            r_out_err <= 1'b1;
            r_out_y   <= '0;
            r_sq_req  <= 1'b0;
            r_timer   <= '0;
            r_state   <= S_REQ_LO;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        S_REQ_LO: begin
          if (!w_fin_s) begin
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else if (w_tmo) begin
            r_out_err   <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign out_err   = r_out_err;
  assign sq_req    = r_sq_req;
  assign sq_x      = r_sq_x;

endmodule

// File: tb/tb_sqrt_sync_bridge.sv
// Directed bench for sqrt_sync_bridge with a behavioural self-timed sqrt model.
`timescale 1ns/1ps
module tb_sqrt_sync_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_y;
  logic        out_err;
  logic        sq_req;
  logic [31:0] sq_x;
  logic        sq_fin;
  logic [31:0] sq_y;

  int checks = 0;
  int errors = 0;

  // 0: random 0-40 ns delay, 1: zero delay, 2: never raises fin, 3: holds fin until hold_fin clears
  int mode = 0;
  bit hold_fin = 1'b0;

  always #5 clk = ~clk;

  sqrt_sync_bridge #(.Width(32), .SyncStages(2), .Timeout(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_err(out_err),
    .sq_req(sq_req), .sq_x(sq_x), .sq_fin(sq_fin), .sq_y(sq_y)
  );

  function automatic logic [31:0] isqrt(input logic [31:0] x);
    longint unsigned r = 0;
    longint unsigned t;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= {32'd0, x}) r = t;
    end
    return r[31:0];
  endfunction

  initial begin
    int d;
    sq_fin = 1'b0;
    sq_y   = '0;
    forever begin
      wait (sq_req === 1'b1);
      if (mode == 2) begin
        wait (sq_req === 1'b0);
      end else begin
        d = (mode == 0) ? $urandom_range(0, 40) : 0;
        if (d != 0) #(d);
        sq_y   = isqrt(sq_x);
        sq_fin = 1'b1;
        wait (sq_req === 1'b0);
        if (mode == 3) wait (hold_fin == 1'b0);
        d = (mode == 0) ? $urandom_range(0, 40) : 0;
        if (d != 0) #(d);
        sq_fin = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x, input string nm, output bit ok);
    in_x = x;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (in_ready === 1'b1) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s accept: in_ready stayed %b, required 1", nm, in_ready);
    end
  endtask

  task automatic wait_out(input string nm, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s result: out_valid stayed %b, required 1", nm, out_valid);
    end
  endtask

  task automatic pop_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [31:0] x, input logic [31:0] ey, input logic ee, input string nm);
    bit ok;
    send(x, nm, ok);
    if (!ok) return;
    wait_out(nm, ok);
    if (!ok) return;
    checks++;
    if (out_y !== ey) begin
      errors++;
      $display("FAIL %s out_y: got %0d, required %0d", nm, out_y, ey);
    end
    checks++;
    if (out_err !== ee) begin
      errors++;
      $display("FAIL %s out_err: got %b, required %b", nm, out_err, ee);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s in_ready with out_valid: got %b, required 0", nm, in_ready);
    end
    pop_result();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    checks++;
    if ({sq_req, sq_x, out_valid, out_y, out_err} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got req=%b x=%0d ov=%b y=%0d err=%b, required all 0",
               sq_req, sq_x, out_valid, out_y, out_err);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset in_ready: got %b, required 1", in_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    mode = 0;
    do_op(32'd144, 32'd12, 1'b0, "basic_144");
    do_op(32'hFFFF_FFFF, 32'd65535, 1'b0, "basic_max");
    do_op(32'd2, 32'd1, 1'b0, "basic_2");
  endtask

  task automatic test_latency();
    bit ok;
    mode = 1;
    send(32'd144, "latency", ok);
    checks++;
    if (sq_req !== 1'b1) begin
      errors++;
      $display("FAIL latency req_e0: got %b, required 1", sq_req);
    end
    tick(); tick();
    checks++;
    if (sq_req !== 1'b1) begin
      errors++;
      $display("FAIL latency req_e2: got %b, required 1", sq_req);
    end
    tick();
    checks++;
    if (sq_req !== 1'b0) begin
      errors++;
      $display("FAIL latency req_e3: got %b, required 0", sq_req);
    end
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency valid_e5: got %b, required 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_y !== 32'd12) begin
      errors++;
      $display("FAIL latency valid_e6: got valid=%b y=%0d, required valid=1 y=12", out_valid, out_y);
    end
    pop_result();
    mode = 0;
  endtask

  task automatic test_backpressure();
    bit ok;
    mode = 0;
    send(32'd81, "bp", ok);
    wait_out("bp", ok);
    in_x = 32'd100;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_y !== 32'd9 || in_ready !== 1'b0 || sq_req !== 1'b0) begin
        errors++;
        $display("FAIL bp hold[%0d]: got valid=%b y=%0d in_ready=%b req=%b, required 1/9/0/0",
                 i, out_valid, out_y, in_ready, sq_req);
      end
      tick();
    end
    pop_result();
    checks++;
    if (out_valid !== 1'b0 || sq_req !== 1'b0) begin
      errors++;
      $display("FAIL bp release: got valid=%b req=%b, required 0/0", out_valid, sq_req);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (sq_req !== 1'b1 || sq_x !== 32'd100) begin
      errors++;
      $display("FAIL bp next_accept: got req=%b x=%0d, required 1/100", sq_req, sq_x);
    end
    wait_out("bp_next", ok);
    checks++;
    if (out_y !== 32'd10) begin
      errors++;
      $display("FAIL bp next_y: got %0d, required 10", out_y);
    end
    pop_result();
  endtask

  task automatic test_timeout();
    bit ok;
    mode = 2;
    send(32'd1000, "timeout", ok);
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (sq_req !== 1'b1) begin
      errors++;
      $display("FAIL timeout req_e15: got %b, required 1", sq_req);
    end
    tick();
    checks++;
    if (sq_req !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout req_e16: got req=%b valid=%b, required 0/0", sq_req, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || out_y !== 32'd0) begin
      errors++;
      $display("FAIL timeout result: got valid=%b err=%b y=%0d, required 1/1/0", out_valid, out_err, out_y);
    end
    pop_result();
    mode = 0;
    do_op(32'd25, 32'd5, 1'b0, "after_timeout");
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    mode = 3;
    hold_fin = 1'b1;
    send(32'd200, "rst_mid", ok);
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sq_req, sq_x, out_valid, out_y, out_err} !== '0) begin
      errors++;
      $display("FAIL rst_mid outputs: got req=%b x=%0d ov=%b y=%0d err=%b, required all 0",
               sq_req, sq_x, out_valid, out_y, out_err);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid stale_fin: in_ready got %b, required 0", in_ready);
    end
    hold_fin = 1'b0;
    #1;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid drain1: in_ready got %b, required 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid drain2: in_ready got %b, required 1", in_ready);
    end
    mode = 0;
    do_op(32'd49, 32'd7, 1'b0, "after_rst");
  endtask

  task automatic test_stream();
    logic [31:0] exp_q[$];
    int got = 0;
    fork
      begin
        bit ok;
        logic [31:0] x;
        for (int i = 0; i < 1000; i++) begin
          x = (i % 4 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
          send(x, "stream", ok);
          if (!ok) break;
          exp_q.push_back(isqrt(x));
        end
      end
      begin
        logic [31:0] e;
        for (int c = 0; c < 40000 && got < 1000; c++) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid === 1'b1 && out_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (out_y !== e || out_err !== 1'b0) begin
              errors++;
              $display("FAIL stream[%0d]: got y=%0d err=%b, required y=%0d err=0", got, out_y, out_err, e);
            end
            got++;
          end
          tick();
        end
        out_ready = 1'b0;
      end
    join
    checks++;
    if (got != 1000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream count: got %0d results with %0d pending, required 1000 and 0", got, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_backpressure();
    test_timeout();
    test_reset_mid_op();
    test_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sqrt_sync_bridge.md
# sqrt_sync_bridge

Clocked front-end for the self-timed `sqrt` stage. It accepts operands from synchronous logic over a valid/ready handshake and drives them into `sqrt`'s req/fin bundled-data interface. It synchronises `fin`, captures the root, and returns it over a valid/ready output. It sits directly upstream of `sqrt` and is also the consumer of its result. A timeout guards against a stalled self-timed stage.

## Interface
- `Width`, 32: operand/result width; must equal the `Width` of the attached `sqrt`.
- `SyncStages`, 2: flops in the `sq_fin` synchroniser, minimum 2.
- `Timeout`, 1023: cycles allowed per handshake phase before abort; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  bridge can accept an operand.
- `in_x`  in  Width  radicand.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_y`  out  Width  integer root.
- `out_err`  out  1  result aborted by timeout.
- `sq_req`  out  1  req to `sqrt`, registered.
- `sq_x`  out  Width  operand to `sqrt`, registered.
- `sq_fin`  in  1  fin from `sqrt`, asynchronous to `clk`.
- `sq_y`  in  Width  root from `sqrt`, bundled with `sq_fin`.

## Operation
- Four-phase return-to-zero handshake to `sqrt`:
  - raise `sq_req`;
  - wait for `fin` high;
  - drop `sq_req`;
  - wait for `fin` low.
- `fin_s` is the output of the last synchroniser flop. The FSM uses only `fin_s`, never raw `sq_fin`.
- `in_ready = (state==IDLE) && !fin_s`. This refuses a new request while a stale `fin` is still high, for example after a reset mid-operation.
- FSM states and transitions:
  - **IDLE**: on `in_valid && in_ready`, latch `in_x` into `sq_x`, set `sq_req=1`, clear the timer and `out_err`, go to REQ_HI.
  - **REQ_HI**: if `fin_s`, capture `sq_y` into `out_y`, set `sq_req=0`, clear the timer, go to REQ_LO. Otherwise, if `Timeout!=0` and timer==`Timeout-1`, set `out_err=1`, `out_y=0`, `sq_req=0`, clear the timer, go to REQ_LO. Otherwise increment the timer.
  - **REQ_LO**: if `!fin_s`, go to OUT and set `out_valid=1`. On the same timeout condition, set `out_err=1` and go to OUT.
  - **OUT**: hold `out_valid`, `out_y` and `out_err` until `out_ready`. Then clear `out_valid` and go to IDLE.
- `sq_x` stays stable from the rise of `sq_req` until the bridge leaves REQ_LO, which meets the bundled-data constraint. `sq_y` is sampled only after `fin_s` is high, so it is guaranteed settled.
- The timer is `$clog2(Timeout+1)` bits wide and saturates; it never wraps.
- The bridge does no arithmetic on the value. `out_y` is exactly the `sq_y` sampled at capture.

## Timing
- Reset values: state IDLE, `sq_req=0`, `sq_x=0`, `out_valid=0`, `out_y=0`, `out_err=0`, synchroniser flops 0, timer 0.
- The reset is asynchronous and takes effect immediately. Reset mid-operation discards the operation and drops `sq_req`. No result is produced.
- Minimum latency is `2*(SyncStages+1)` cycles, i.e. 6 with defaults. This is measured from the accepting edge to the edge after which `out_valid=1`, assuming zero `sqrt` delay. Each handshake phase costs its `sqrt` delay rounded up to the next edge, plus `SyncStages+1` cycles.
- Throughput is one operation in flight. The next operand can be accepted on the edge after `out_valid && out_ready`, and only once `fin_s` is low.
- `in_ready` and `out_valid` are never high in the same cycle.
- If `fin` rises after a timeout, it is ignored in REQ_LO and OUT. IDLE then blocks until `fin_s` falls.

## Test plan
- **Basic results**, using a behavioural `sqrt` model with a random 0–40 ns delay, 10 ns clock:
  - `in_x`=144 → `out_y`=12, `out_err`=0.
  - `in_x`=0xFFFFFFFF → `out_y`=65535.
  - `in_x`=2 → `out_y`=1.
- **Minimum latency**: zero-delay model. Accept at edge 0 → `sq_req` low after edge 3, `out_valid` high after edge 6.
- **Back-pressure**: hold `out_ready`=0 for 10 cycles with `in_x`=81. `out_y`=9 stays stable, `in_ready`=0 throughout, and the next operand is accepted only after the `out_ready` pulse.
- **Timeout**: `Timeout`=16 and a model that never raises `fin` → `out_err`=1, `out_y`=0, `sq_req` low 16 cycles after acceptance. A following `in_x`=25 returns 5 with `out_err`=0.
- **Reset mid-operation**: assert `rst_n`=0 while in REQ_HI with model `fin` high → outputs go to reset values at once. After release, `in_ready` stays 0 until `fin` falls plus `SyncStages` cycles. The next `in_x`=49 returns 7.
- **Stream**: 1000 random operands under random `out_ready` → every result equals `floor(sqrt(x))` and arrives in order, with no drops and no duplicates.
